// File: rtl/dll_pkg.sv
// Shared data link layer definitions: frame layout, LCRC constants and helpers.
// Used by both the TX and RX data link layers so the two ends frame identically.
package dll_pkg;

    localparam int unsigned FRAME_W     = 48;
    localparam int unsigned PAYLOAD_LSB = 0;
    localparam int unsigned PAYLOAD_MSB = 31;
    localparam int unsigned SEQ_LSB     = 32;
    localparam int unsigned SEQ_MSB     = 39;
    localparam int unsigned CRC_LSB     = 40;
    localparam int unsigned CRC_MSB     = 47;

    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'hFF;

    typedef enum logic [1:0] {
        SEQ_INORDER,
        SEQ_DUP,
        SEQ_AHEAD
    } seq_class_e;

    // Bit-serial CRC-8, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_calc(
        input logic [39:0] data,
        input logic [7:0]  poly = CRC_POLY,
        input logic [7:0]  init = CRC_INIT
    );
        logic [7:0] crc;
        crc = init;
        for (int i = 39; i >= 0; i--) begin
            if (crc[7] ^ data[i]) begin
                crc = {crc[6:0], 1'b0} ^ poly;
            end else begin
                crc = {crc[6:0], 1'b0};
            end
        end
        return crc;
    endfunction

endpackage

// File: rtl/dll_lcrc8.sv
// Combinational CRC-8 over the 40-bit sequence+payload field of a link frame.
// Shared by the TX side for generation and the RX side for checking.
module dll_lcrc8
    import dll_pkg::*;
#(
    parameter logic [7:0] POLY = CRC_POLY,
    parameter logic [7:0] INIT = CRC_INIT
) (
    input  logic [39:0] data,
    output logic [7:0]  crc
);

    always_comb begin
        crc = crc8_calc(data, POLY, INIT);
    end

endmodule

// File: rtl/rx_data_link_layer.sv
// Receive data link layer: checks LCRC and sequence number of incoming frames,
// forwards in-order good payloads and returns ack/nack pulses to the transmitter.
module rx_data_link_layer
    import dll_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEQ_W  = 8,
    parameter int unsigned CRC_W  = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [DATA_W+SEQ_W+CRC_W-1:0]   frame_in,
    input  logic                            frame_in_valid,
    output logic                            frame_in_ready,
    output logic [DATA_W-1:0]               tlp_data_out,
    output logic                            tlp_data_out_valid,
    input  logic                            tlp_data_out_ready,
    output logic                            ack,
    output logic                            nack,
    output logic [SEQ_W-1:0]                ack_seq
);

    logic [SEQ_W-1:0]  rx_seq;
    logic [SEQ_W-1:0]  seq_diff;
    logic [SEQ_W-1:0]  expected_seq;
    logic [CRC_W-1:0]  rx_crc;
    logic [CRC_W-1:0]  calc_crc;
    logic [DATA_W-1:0] rx_payload;
    logic              nak_pending;
    logic              crc_ok;
    logic              accept;
    seq_class_e        seq_class;

    assign rx_crc     = frame_in[CRC_MSB:CRC_LSB];
    assign rx_seq     = frame_in[SEQ_MSB:SEQ_LSB];
    assign rx_payload = frame_in[PAYLOAD_MSB:PAYLOAD_LSB];

    dll_lcrc8 #(
        .POLY (CRC_POLY),
        .INIT (CRC_INIT)
    ) u_lcrc (
        .data (frame_in[SEQ_MSB:PAYLOAD_LSB]),
        .crc  (calc_crc)
    );

    assign crc_ok = (calc_crc == rx_crc);

    // Distance ahead of the expected sequence; the upper half of the ring counts as already seen.
    always_comb begin
        seq_diff = rx_seq - expected_seq;
        if (seq_diff == '0) begin
            seq_class = SEQ_INORDER;
        end else if (seq_diff[SEQ_W-1]) begin
            seq_class = SEQ_DUP;
        end else begin
            seq_class = SEQ_AHEAD;
        end
    end

    // Held low in reset so nothing is taken while state is being cleared.
    assign frame_in_ready = reset_n && (!tlp_data_out_valid || tlp_data_out_ready);
    assign accept         = frame_in_valid && frame_in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tlp_data_out       <= '0;
            tlp_data_out_valid <= 1'b0;
            ack                <= 1'b0;
            nack               <= 1'b0;
            ack_seq            <= '1;
            expected_seq       <= '0;
            nak_pending        <= 1'b0;
        end else begin
            ack  <= 1'b0;
            nack <= 1'b0;
            if (tlp_data_out_ready) begin
                tlp_data_out_valid <= 1'b0;
            end
            if (accept) begin
                if (crc_ok && seq_class == SEQ_INORDER) begin
                    tlp_data_out       <= rx_payload;
                    tlp_data_out_valid <= 1'b1;
                    expected_seq       <= expected_seq + 1'b1;
                    nak_pending        <= 1'b0;
                    ack                <= 1'b1;
                    ack_seq            <= rx_seq;
                end else if (crc_ok && seq_class == SEQ_DUP) begin
                    ack     <= 1'b1;
                    ack_seq <= expected_seq - 1'b1;
                end else if (!nak_pending) begin
                    // Corrupt or out-of-order: request one retry until progress resumes.
                    nack        <= 1'b1;
                    ack_seq     <= expected_seq - 1'b1;
                    nak_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_data_link_layer.sv
// Self-checking bench for rx_data_link_layer: reference model feeds payload and
// ack/nack scoreboards that are drained as the DUT produces output.
module tb_rx_data_link_layer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [47:0] frame_in;
    logic        frame_in_valid;
    logic        frame_in_ready;
    logic [31:0] tlp_data_out;
    logic        tlp_data_out_valid;
    logic        tlp_data_out_ready;
    logic        ack;
    logic        nack;
    logic [7:0]  ack_seq;

    always #5 clk = ~clk;

    rx_data_link_layer dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .frame_in           (frame_in),
        .frame_in_valid     (frame_in_valid),
        .frame_in_ready     (frame_in_ready),
        .tlp_data_out       (tlp_data_out),
        .tlp_data_out_valid (tlp_data_out_valid),
        .tlp_data_out_ready (tlp_data_out_ready),
        .ack                (ack),
        .nack               (nack),
        .ack_seq            (ack_seq)
    );

    typedef struct packed {
        logic [1:0] kind;  // {ack, nack}
        logic [7:0] seq;
    } pulse_t;

    pulse_t      pulse_q[$];
    logic [31:0] data_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [7:0] m_exp;
    logic       m_nak;
    logic       m_out_valid;
    logic [7:0] m_ack_seq;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Byte-at-a-time formulation of the MSB-first CRC-8.
    function automatic logic [7:0] ref_crc(input logic [39:0] d);
        logic [7:0] c;
        c = 8'hFF;
        for (int b = 4; b >= 0; b--) begin
            c = c ^ d[b*8 +: 8];
            for (int k = 0; k < 8; k++) begin
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
            end
        end
        return c;
    endfunction

    function automatic logic [47:0] mk(input logic [7:0] seq, input logic [31:0] payload);
        return {ref_crc({seq, payload}), seq, payload};
    endfunction

    // One clock: drive at negedge, check combinational/held state, update model, check pulses.
    task automatic step(input logic v, input logic [47:0] f, input logic r);
        logic       rdy_m;
        logic       acc;
        logic       ok;
        logic [7:0] sq;
        logic [7:0] d;
        pulse_t     p;
        frame_in           = f;
        frame_in_valid     = v;
        tlp_data_out_ready = r;
        #1;
        rdy_m = !m_out_valid || r;
        check("in_ready", {47'd0, frame_in_ready}, {47'd0, rdy_m});
        check("out_valid", {47'd0, tlp_data_out_valid}, {47'd0, m_out_valid});
        check("ack_seq_hold", {40'd0, ack_seq}, {40'd0, m_ack_seq});
        if (m_out_valid) begin
            if (data_q.size() == 0) begin
                n_checks++;
                $display("FAIL data_q: got %0h expected none at %0t", tlp_data_out, $time);
            end else begin
                check("data", {16'd0, tlp_data_out}, {16'd0, data_q[0]});
                if (r) void'(data_q.pop_front());
            end
        end
        acc = v && rdy_m;
        if (r) m_out_valid = 1'b0;
        if (acc) begin
            sq = f[39:32];
            d  = sq - m_exp;
            ok = (ref_crc(f[39:0]) == f[47:40]);
            if (ok && d == 8'd0) begin
                data_q.push_back(f[31:0]);
                m_out_valid = 1'b1;
                pulse_q.push_back({2'b10, sq});
                m_exp = m_exp + 8'd1;
                m_nak = 1'b0;
            end else if (ok && d >= 8'd128) begin
                pulse_q.push_back({2'b10, m_exp - 8'd1});
            end else if (!m_nak) begin
                pulse_q.push_back({2'b01, m_exp - 8'd1});
                m_nak = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (pulse_q.size() == 0) begin
            check("no_pulse", {46'd0, ack, nack}, 48'd0);
        end else begin
            p = pulse_q.pop_front();
            check("pulse_kind", {46'd0, ack, nack}, {46'd0, p.kind});
            check("pulse_seq", {40'd0, ack_seq}, {40'd0, p.seq});
            m_ack_seq = p.seq;
        end
    endtask

    // Asynchronous reset entered at a negedge; outputs are checked before any clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_valid", {47'd0, tlp_data_out_valid}, 48'd0);
        check("rst_data", {16'd0, tlp_data_out}, 48'd0);
        check("rst_ack", {46'd0, ack, nack}, 48'd0);
        check("rst_ack_seq", {40'd0, ack_seq}, 48'hFF);
        check("rst_in_ready", {47'd0, frame_in_ready}, 48'd0);
        frame_in_valid = 1'b0;
        pulse_q.delete();
        data_q.delete();
        m_exp       = 8'd0;
        m_nak       = 1'b0;
        m_out_valid = 1'b0;
        m_ack_seq   = 8'hFF;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [47:0] bad;
        reset_n            = 1'b1;
        frame_in           = '0;
        frame_in_valid     = 1'b0;
        tlp_data_out_ready = 1'b1;
        @(negedge clk);
        do_reset();

        // In-order good frames with an always-ready sink.
        for (int i = 0; i < 3; i++) step(1'b1, mk(i[7:0], 32'hA5A5_0000 + i), 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Corrupt frames: single nack, then recovery clears the pending nack.
        do_reset();
        bad = mk(8'd0, 32'h1111_0000) ^ (48'h1 << 40);
        step(1'b1, bad, 1'b1);
        step(1'b1, mk(8'd0, 32'h2222_0000) ^ (48'h1 << 5), 1'b1);
        step(1'b1, mk(8'd0, 32'h3333_0000), 1'b1);
        step(1'b1, bad, 1'b1);
        step(1'b0, '0, 1'b1);

        // Duplicate and ahead-of-sequence handling.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, mk(i[7:0], 32'hC0DE_0000 + i), 1'b1);
        step(1'b1, mk(8'd3, 32'hDEAD_0003), 1'b1);
        step(1'b1, mk(8'd7, 32'hBEEF_0007), 1'b1);
        step(1'b1, mk(8'd7, 32'hBEEF_0007), 1'b1);
        step(1'b1, mk(8'd5, 32'hC0DE_0005), 1'b1);
        step(1'b0, '0, 1'b1);

        // Sequence wrap over 260 back-to-back frames.
        do_reset();
        for (int i = 0; i < 260; i++) step(1'b1, mk(i[7:0], $urandom), 1'b1);
        step(1'b0, '0, 1'b1);

        // Backpressure, drain, then reset during a stall.
        do_reset();
        step(1'b1, mk(8'd0, 32'h5000_0000), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, mk(8'd1, 32'h5000_0001), 1'b0);
        for (int i = 1; i < 4; i++) step(1'b1, mk(i[7:0], 32'h5000_0000 + i), 1'b1);
        step(1'b1, mk(8'd4, 32'h5000_0004), 1'b0);
        step(1'b1, mk(8'd5, 32'h5000_0005), 1'b0);
        frame_in_valid = 1'b1;
        do_reset();
        step(1'b1, mk(8'd0, 32'h6000_0000), 1'b1);
        step(1'b0, '0, 1'b1);

        if (pulse_q.size() != 0 || data_q.size() != 0) begin
            n_checks++;
            $display("FAIL leftover: got %0d pulses %0d payloads expected 0 0",
                     pulse_q.size(), data_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_data_link_layer.md
Name: rx_data_link_layer

Overview:
- Receive-side data link layer. Consumes 48-bit link frames delivered by the physical layer, checks the LCRC and sequence number, and forwards good payloads to the transaction layer over a valid/ready interface.
- Generates the ack/nack pulses that are returned to the transmitting TX data link layer.
- Is the link partner of the TX data link layer: consumes exactly the frame format that block produces.

Parameters:
- DATA_W, 32, payload width in bits.
- SEQ_W, 8, sequence number width in bits.
- CRC_W, 8, LCRC width in bits. DATA_W+SEQ_W+CRC_W must equal 48.
- CRC_POLY, 8'h07, LCRC polynomial x^8+x^2+x+1.
- CRC_INIT, 8'hFF, LCRC seed.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_in  in  48  frame from physical layer; [47:40] LCRC, [39:32] sequence number, [31:0] payload.
- frame_in_valid  in  1  frame present.
- frame_in_ready  out  1  block accepts frame this cycle.
- tlp_data_out  out  32  payload to transaction layer.
- tlp_data_out_valid  out  1  payload valid.
- tlp_data_out_ready  in  1  transaction layer accepts payload.
- ack  out  1  one-cycle pulse: frame acknowledged.
- nack  out  1  one-cycle pulse: frame rejected, retry requested.
- ack_seq  out  8  sequence number qualified by ack/nack.

Behaviour:
- Reset (asynchronous, reset_n=0) values:
  - tlp_data_out_valid=0, tlp_data_out=0, ack=0, nack=0, ack_seq=8'hFF.
  - expected_seq=0, nak_pending=0.
  - frame_in_ready drops to 0 while in reset.
  - Any frame in flight is discarded. No ack or nack is emitted for it.
- Accept rule: frame_in_ready = !tlp_data_out_valid || tlp_data_out_ready. A frame is accepted on a cycle where frame_in_valid && frame_in_ready. Bad and duplicate frames are also stalled by a full output slot.
- LCRC check:
  - CRC-8 with CRC_POLY, seeded CRC_INIT, computed over frame_in[39:0] MSB first. No reflection, no final XOR.
  - The check is combinational in the accept cycle.
  - Match means crc_ok.
- Sequence classification: d = (rx_seq - expected_seq) mod 256.
  - d==0: in-order.
  - d in 128..255: duplicate.
  - d in 1..127: ahead.
- Decision, registered in the cycle after accept (latency 1):
  - crc_ok and in-order:
    - Load tlp_data_out with the payload and set tlp_data_out_valid.
    - expected_seq <= expected_seq+1 (wraps 255 -> 0).
    - nak_pending <= 0.
    - ack=1, ack_seq=rx_seq.
  - crc_ok and duplicate: drop the payload. ack=1, ack_seq=expected_seq-1.
  - crc_ok and ahead: drop the payload.
    - If !nak_pending: nack=1, ack_seq=expected_seq-1, nak_pending <= 1.
    - Otherwise: no pulse.
  - !crc_ok (sequence ignored): drop the payload. Same nack/nak_pending rule as the ahead case.
- ack and nack are mutually exclusive and last one cycle. ack_seq holds its value between pulses.
- Output register:
  - Cleared on the tlp_data_out_ready handshake unless reloaded in the same cycle.
  - Simultaneous drain and load means back-to-back throughput of 1 frame/cycle.
  - tlp_data_out is stable while valid && !ready.
- Reset mid-operation: a pending output payload is lost. The transmitter recovers through its retry buffer.

Decomposition:
- dll_pkg:
  - frame field bit positions.
  - CRC_POLY and CRC_INIT.
  - Sequence-classification enum {SEQ_INORDER, SEQ_DUP, SEQ_AHEAD}.
  - Function crc8_calc(input [39:0]).
- Shared with the TX data link layer so both ends use identical framing.
- One natural sub-module, dll_lcrc8: a combinational CRC-8 generator. It is reused by TX for generation and by RX for checking.

Test Plan:
- Reset, then 3 good frames with seq 0,1,2 and payloads 32'hA5A5_0000..0002, sink always ready -> payloads out in order at 1-cycle latency. ack pulses with ack_seq 0,1,2; no nack.
- Frame seq 0 with LCRC bit 0 flipped, then a second corrupt frame -> exactly one nack with ack_seq=8'hFF. No payload out. Then a good seq 0 -> ack 0, nak_pending cleared.
- After seq 0..4 accepted, resend seq 3 -> ack with ack_seq=4, payload dropped, expected_seq stays 5.
- With expected_seq=5, send seq 7 -> nack with ack_seq=4. Send seq 7 again -> no pulse. Send seq 5 -> ack 5, payload forwarded.
- Run 260 consecutive good frames -> expected_seq wraps 255 -> 0. Frame seq 0 after the wrap is in-order and acked.
- Hold tlp_data_out_ready=0 with frames valid -> frame_in_ready=0 after the first frame, tlp_data_out stable. Release ready -> back-to-back drain. Assert reset_n=0 mid-stall -> all outputs return to reset values immediately.
